// File: rtl/tmds_decoder_if.sv
// Signal bundle between a TMDS channel deserializer/sink and the TMDS decoder.
// de qualifies data_out; there is no backpressure: one result per clock and the sink must take it.
interface tmds_decoder_if;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de;
  logic       locked;
  logic       bitslip;
  logic [1:0] fsm_state;

  modport master (
    output tmds_in,
    input  data_out, ctrl_out, de, locked, bitslip, fsm_state
  );

  modport slave (
    input  tmds_in,
    output data_out, ctrl_out, de, locked, bitslip, fsm_state
  );
endinterface

// File: rtl/tmds_decoder.sv
// One-channel TMDS receive decoder: 2-stage pipeline, control-token word alignment
// with a bitslip request to the deserializer while alignment is being searched.
module tmds_decoder #(
  parameter int TOKEN_COUNT   = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int SLIP_SETTLE   = 16
) (
  input  logic          clk,
  input  logic          reset,
  tmds_decoder_if.slave bus
);
  localparam int TW  = $clog2(TOKEN_COUNT) + 1;
  localparam int WW  = $clog2(SEARCH_WINDOW) + 1;
  localparam int STW = $clog2(SLIP_SETTLE) + 1;
  localparam logic [TW-1:0]  TOK_LOCK = TW'(TOKEN_COUNT);
  localparam logic [WW-1:0]  WIN_LAST = WW'(SEARCH_WINDOW - 1);
  localparam logic [STW-1:0] SET_LAST = STW'(SLIP_SETTLE - 1);

  typedef enum logic [1:0] {SEARCH, SLIP, SETTLE, LOCKED} state_t;

  state_t         state, state_n;
  logic [TW-1:0]  tok_cnt, tok_n, tok_inc;
  logic [WW-1:0]  win_cnt, win_n, win_inc;
  logic [WW-1:0]  gap_cnt, gap_n, gap_inc;
  logic [STW-1:0] set_cnt, set_n, set_inc;

  logic       tok_hit;
  logic [1:0] tok_code;
  logic [9:0] s1_word;
  logic       s1_tok;
  logic [1:0] s1_code;
  logic [7:0] d, q;
  logic [7:0] data_q;
  logic [1:0] ctrl_q;
  logic       de_q;

  always_comb begin
    tok_hit  = 1'b1;
    tok_code = 2'b00;
    case (bus.tmds_in)
      10'b1101010100: tok_code = 2'b00;
      10'b0010101011: tok_code = 2'b01;
      10'b0101010100: tok_code = 2'b10;
      10'b1010101011: tok_code = 2'b11;
      default:        tok_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_word <= '0;
      s1_tok  <= 1'b0;
      s1_code <= 2'b00;
    end else begin
      s1_word <= bus.tmds_in;
      s1_tok  <= tok_hit;
      s1_code <= tok_code;
    end
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    d    = s1_word[9] ? ~s1_word[7:0] : s1_word[7:0];
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++)
      q[i] = s1_word[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  assign tok_inc = (&tok_cnt) ? tok_cnt : tok_cnt + TW'(1);
  assign win_inc = (&win_cnt) ? win_cnt : win_cnt + WW'(1);
  assign gap_inc = (&gap_cnt) ? gap_cnt : gap_cnt + WW'(1);
  assign set_inc = (&set_cnt) ? set_cnt : set_cnt + STW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SEARCH;
      tok_cnt <= '0;
      win_cnt <= '0;
      gap_cnt <= '0;
      set_cnt <= '0;
    end else begin
      state   <= state_n;
      tok_cnt <= tok_n;
      win_cnt <= win_n;
      gap_cnt <= gap_n;
      set_cnt <= set_n;
    end
  end

  always_comb begin
    state_n = state;
    tok_n   = tok_cnt;
    win_n   = win_cnt;
    gap_n   = gap_cnt;
    set_n   = set_cnt;
    case (state)
      SEARCH: begin
        win_n = win_inc;
        tok_n = s1_tok ? tok_inc : '0;
        // A completed token run wins over an expiring window in the same cycle.
        if (s1_tok && (tok_inc >= TOK_LOCK)) begin
          state_n = LOCKED;
          gap_n   = '0;
        end else if (win_cnt == WIN_LAST) begin
          state_n = SLIP;
        end
      end
      SLIP: begin
        state_n = SETTLE;
        set_n   = '0;
      end
      SETTLE: begin
        tok_n = '0;
        if (set_cnt == SET_LAST) begin
          state_n = SEARCH;
          win_n   = '0;
        end else begin
          set_n = set_inc;
        end
      end
      LOCKED: begin
        if (s1_tok) begin
          gap_n = '0;
        end else if (gap_cnt == WIN_LAST) begin
          state_n = SEARCH;
          win_n   = '0;
          tok_n   = '0;
        end else begin
          gap_n = gap_inc;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  // de is gated by the next state so it never outlives locked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      ctrl_q <= 2'b00;
      de_q   <= 1'b0;
    end else if (s1_tok) begin
      data_q <= '0;
      ctrl_q <= s1_code;
      de_q   <= 1'b0;
    end else begin
      data_q <= (state_n == LOCKED) ? q : 8'h00;
      de_q   <= (state_n == LOCKED);
    end
  end

  assign bus.data_out  = data_q;
  assign bus.ctrl_out  = ctrl_q;
  assign bus.de        = de_q;
  assign bus.locked    = (state == LOCKED);
  assign bus.bitslip   = (state == SLIP);
  assign bus.fsm_state = state;
endmodule
